// File: rtl/simd_loop_group_scheduler.sv
// Time-shares one SIMD loop-nest controller between up to NUM_MAX_GROUPS loop groups.
// Groups rotate round-robin on completion, time-slice expiry or requester drop-out.
module simd_loop_group_scheduler #(
  parameter int GROUP_ID_W     = 2,
  parameter int NUM_MAX_GROUPS = 1 << GROUP_ID_W,
  parameter int QUANTUM_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      block_start,
  input  logic                      cfg_loop_iter_v,
  input  logic [GROUP_ID_W-1:0]     cfg_loop_group_id,
  input  logic [NUM_MAX_GROUPS-1:0] grp_req,
  input  logic [QUANTUM_W-1:0]      quantum,
  input  logic                      loop_done,
  output logic                      start,
  output logic [GROUP_ID_W-1:0]     loop_group_id,
  output logic                      stall,
  output logic                      block_done,
  output logic                      busy,
  output logic [NUM_MAX_GROUPS-1:0] grp_finished
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_SWITCH,
    S_FINISH
  } state_e;

  state_e                    state_q, state_d;
  logic [GROUP_ID_W-1:0]     loop_group_id_q, loop_group_id_d;
  logic [GROUP_ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_MAX_GROUPS-1:0] grp_finished_q, grp_finished_d;
  logic [NUM_MAX_GROUPS-1:0] cfg_mask_q, cfg_mask_d;
  logic [QUANTUM_W-1:0]      slice_cnt_q, slice_cnt_d;
  logic                      start_q, start_d;
  logic                      block_done_q, block_done_d;
  logic                      busy_q, busy_d;

  logic [NUM_MAX_GROUPS-1:0] active_oh;
  logic [NUM_MAX_GROUPS-1:0] elig_next;
  logic [NUM_MAX_GROUPS-1:0] other_ready;
  logic                      stall_run;
  logic                      slice_end;

  // Upward search from base (wrapping): prefer eligible requesters, else any eligible group.
  function automatic logic [GROUP_ID_W-1:0] pick(
    input logic [GROUP_ID_W-1:0]     base,
    input logic [NUM_MAX_GROUPS-1:0] elig,
    input logic [NUM_MAX_GROUPS-1:0] req
  );
    logic                  found_r;
    logic                  found_e;
    logic [GROUP_ID_W-1:0] win_r;
    logic [GROUP_ID_W-1:0] win_e;
    logic [GROUP_ID_W-1:0] idx;
    found_r = 1'b0;
    found_e = 1'b0;
    win_r   = '0;
    win_e   = '0;
    for (int i = 0; i < NUM_MAX_GROUPS; i++) begin
      idx = base + GROUP_ID_W'(i);
      if (!found_r && elig[idx] && req[idx]) begin
        found_r = 1'b1;
        win_r   = idx;
      end
      if (!found_e && elig[idx]) begin
        found_e = 1'b1;
        win_e   = idx;
      end
    end
    return found_r ? win_r : win_e;
  endfunction

  assign active_oh   = NUM_MAX_GROUPS'(1) << loop_group_id_q;
  assign stall_run   = ~grp_req[loop_group_id_q];
  assign slice_end   = (quantum != '0) && (slice_cnt_q == quantum - QUANTUM_W'(1));
  assign other_ready = cfg_mask_q & ~grp_finished_q & grp_req & ~active_oh;
  assign elig_next   = cfg_mask_q & ~grp_finished_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d         = state_q;
    loop_group_id_d = loop_group_id_q;
    rr_ptr_d        = rr_ptr_q;
    grp_finished_d  = grp_finished_q;
    cfg_mask_d      = cfg_mask_q;
    slice_cnt_d     = slice_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_loop_iter_v) cfg_mask_d[cfg_loop_group_id] = 1'b1;
        if (block_start) begin
          if (cfg_mask_d != '0) begin
            state_d         = S_START;
            loop_group_id_d = pick(GROUP_ID_W'(0), cfg_mask_d, grp_req);
            rr_ptr_d        = loop_group_id_d;
            slice_cnt_d     = '0;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_START:  state_d = S_RUN;
      S_RUN: begin
        if (!stall_run) slice_cnt_d = slice_end ? '0 : slice_cnt_q + QUANTUM_W'(1);
        if (loop_done) grp_finished_d = grp_finished_q | active_oh;
        // Completion outranks slice expiry, which outranks requester drop-out.
        if ((loop_done && elig_next != '0) ||
            (!loop_done && slice_end && !stall_run && other_ready != '0) ||
            (!loop_done && stall_run && other_ready != '0)) begin
          state_d         = S_SWITCH;
          loop_group_id_d = pick(rr_ptr_q + GROUP_ID_W'(1), elig_next, grp_req);
          rr_ptr_d        = loop_group_id_d;
          slice_cnt_d     = '0;
        end else if (loop_done) begin
          state_d = S_FINISH;
        end
      end
      S_SWITCH: state_d = S_RUN;
      S_FINISH: begin
        cfg_mask_d     = '0;
        grp_finished_d = '0;
        state_d        = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign start_d      = (state_d == S_START);
  assign block_done_d = (state_d == S_FINISH);
  assign busy_d       = (state_d != S_IDLE);

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      loop_group_id_q <= '0;
      rr_ptr_q        <= '0;
      grp_finished_q  <= '0;
      cfg_mask_q      <= '0;
      slice_cnt_q     <= '0;
      start_q         <= 1'b0;
      block_done_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      loop_group_id_q <= loop_group_id_d;
      rr_ptr_q        <= rr_ptr_d;
      grp_finished_q  <= grp_finished_d;
      cfg_mask_q      <= cfg_mask_d;
      slice_cnt_q     <= slice_cnt_d;
      start_q         <= start_d;
      block_done_q    <= block_done_d;
      busy_q          <= busy_d;
    end
  end

  assign start         = start_q;
  assign block_done    = block_done_q;
  assign busy          = busy_q;
  assign loop_group_id = loop_group_id_q;
  assign grp_finished  = grp_finished_q;
  assign stall         = (state_q == S_RUN) ? stall_run : 1'b1;

endmodule

// File: tb/tb_simd_loop_group_scheduler.sv
// Scoreboard bench: stimulus queues expected start/switch/done events with their cycle stamps,
// a negedge monitor pops and compares every event the scheduler presents.
module tb_simd_loop_group_scheduler;

  localparam int GW = 2;
  localparam int NG = 4;
  localparam int QW = 8;

  typedef enum logic [1:0] {EV_START, EV_SWITCH, EV_DONE} ev_e;

  logic          clk = 1'b0;
  logic          reset;
  logic          block_start;
  logic          cfg_loop_iter_v;
  logic [GW-1:0] cfg_loop_group_id;
  logic [NG-1:0] grp_req;
  logic [QW-1:0] quantum;
  logic          loop_done;
  logic          start;
  logic [GW-1:0] loop_group_id;
  logic          stall;
  logic          block_done;
  logic          busy;
  logic [NG-1:0] grp_finished;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic [GW-1:0] prev_id = '0;

  simd_loop_group_scheduler #(.GROUP_ID_W(GW), .NUM_MAX_GROUPS(NG), .QUANTUM_W(QW)) dut (
    .clk(clk), .reset(reset), .block_start(block_start),
    .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_group_id(cfg_loop_group_id),
    .grp_req(grp_req), .quantum(quantum), .loop_done(loop_done),
    .start(start), .loop_group_id(loop_group_id), .stall(stall),
    .block_done(block_done), .busy(busy), .grp_finished(grp_finished)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ev(input ev_e k, input logic [GW-1:0] id, input int c);
    return {14'd0, k, 14'd0, (k == EV_DONE) ? 2'd0 : id, c[31:0]};
  endfunction

  task automatic push(input ev_e k, input logic [GW-1:0] id, input int c);
    exp_q.push_back(ev(k, id, c));
  endtask

  // Monitor: any start, block_done, or id change while busy is an observable event.
  always @(negedge clk) begin
    if (reset === 1'b0 && (start || block_done || (busy && loop_group_id != prev_id))) begin
      ev_e k;
      k = start ? EV_START : (block_done ? EV_DONE : EV_SWITCH);
      if (exp_q.size() == 0) begin
        check("unexpected_event", ev(k, loop_group_id, cyc), 64'd0);
      end else begin
        check("event", ev(k, loop_group_id, cyc), exp_q.pop_front());
      end
    end
    prev_id = loop_group_id;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic cfg(input logic [GW-1:0] id);
    cfg_loop_group_id = id;
    cfg_loop_iter_v   = 1'b1;
    tick();
    cfg_loop_iter_v   = 1'b0;
  endtask

  task automatic kick();
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
  endtask

  task automatic finish_group();
    loop_done = 1'b1;
    tick();
    loop_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; block_start = 1'b0; cfg_loop_iter_v = 1'b0; cfg_loop_group_id = '0;
    grp_req = '0; quantum = '0; loop_done = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 1);
    check("rst_start", start, 0);
    check("rst_done", block_done, 0);
    check("rst_id", loop_group_id, 0);
    check("rst_finished", grp_finished, 0);
    reset = 1'b0;
    tick();

    // Groups 0 and 2, no slicing: start, switch on completion, block done.
    cfg(2'd0); cfg(2'd2);
    grp_req = 4'b1111; quantum = 8'd0;
    c = cyc;
    push(EV_START, 2'd0, c + 1);
    kick();
    check("t1_start_stall", stall, 1);
    tick();
    check("t1_run_stall", stall, 0);
    kick();
    tick();
    push(EV_SWITCH, 2'd2, cyc + 1);
    finish_group();
    check("t1_switch_stall", stall, 1);
    tick(); tick();
    push(EV_DONE, 2'd0, cyc + 1);
    finish_group();
    check("t1_fin_flags", grp_finished, 4'b0101);
    tick();
    check("t1_idle_busy", busy, 0);
    check("t1_done_pulse", block_done, 0);
    check("t1_flags_clr", grp_finished, 0);

    // Quantum 4 round-robin between groups 0 and 1, then a lone group never switches.
    cfg(2'd0); cfg(2'd1);
    quantum = 8'd4;
    c = cyc;
    push(EV_START, 2'd0, c + 1);
    push(EV_SWITCH, 2'd1, c + 6);
    push(EV_SWITCH, 2'd0, c + 11);
    push(EV_SWITCH, 2'd1, c + 16);
    kick();
    wait_until(c + 17);
    push(EV_SWITCH, 2'd0, c + 18);
    finish_group();
    wait_until(c + 32);
    push(EV_DONE, 2'd0, cyc + 1);
    finish_group();
    tick();

    // Stall with frozen slice counter, then switch on expiry and on requester drop-out.
    cfg(2'd0); cfg(2'd1);
    grp_req = 4'b0001;
    c = cyc;
    push(EV_START, 2'd0, c + 1);
    kick();
    wait_until(c + 4);
    grp_req = 4'b0000;
    #1 check("t3_stalled", stall, 1);
    wait_until(c + 9);
    push(EV_SWITCH, 2'd1, c + 11);
    grp_req = 4'b0011;
    wait_until(c + 12);
    push(EV_SWITCH, 2'd0, c + 13);
    grp_req = 4'b0001;
    tick(); tick();
    push(EV_SWITCH, 2'd1, cyc + 1);
    finish_group();
    tick();
    check("t3_hold_stall", stall, 1);
    push(EV_DONE, 2'd0, cyc + 1);
    finish_group();
    tick();
    grp_req = 4'b1111;

    // Completion coincides with slice expiry on group 0; group 0 must not return.
    cfg(2'd0); cfg(2'd1);
    quantum = 8'd4;
    c = cyc;
    push(EV_START, 2'd0, c + 1);
    push(EV_SWITCH, 2'd1, c + 6);
    kick();
    wait_until(c + 5);
    finish_group();
    wait_until(c + 25);
    push(EV_DONE, 2'd0, cyc + 1);
    finish_group();
    check("t4_fin_flags", grp_finished, 4'b0011);
    tick();

    // Empty block: no start, block_done next cycle; second block_start is ignored.
    push(EV_DONE, 2'd0, cyc + 1);
    block_start = 1'b1;
    tick(); tick();
    block_start = 1'b0;
    check("t5_idle", busy, 0);
    tick();

    // Reset mid-RUN on group 2, then an empty block.
    quantum = 8'd0;
    cfg(2'd1); cfg(2'd2);
    c = cyc;
    push(EV_START, 2'd1, c + 1);
    push(EV_SWITCH, 2'd2, c + 4);
    kick();
    wait_until(c + 3);
    finish_group();
    tick(); tick();
    check("t6_run_id", loop_group_id, 2'd2);
    reset = 1'b1;
    tick();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_stall", stall, 1);
    check("t6_rst_id", loop_group_id, 0);
    check("t6_rst_flags", grp_finished, 0);
    reset = 1'b0;
    tick();
    push(EV_DONE, 2'd0, cyc + 1);
    kick();
    tick(); tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
